prbs31_checker: RTL

Receive-side checker for the PRBS31 test pattern (x^31 + x^28 + 1) that the on-chip generator drives out on its serial output pin. It sits directly downstream of the generator, either on-chip loopback or fed from an external return path. It self-synchronises to the incoming bit stream and declares lock after a run of error-free bits. Once locked, it free-runs its own reference sequence, counts bit errors and compared bits, and drops lock when the error density gets too high.

---
 rtl/prbs31_checker.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/prbs31_checker.sv
// prbs31_checker
//   Receive-side checker for the PRBS31 pattern (x^31 + x^28 + 1).
//   Self-synchronises by loading the incoming stream into its own shift
//   register, declares lock after LOCK_COUNT consecutive correct predictions,
//   then free-runs its reference sequence and counts bit errors. Lock is
//   dropped when LOSS_THRESH errors land inside one LOSS_WINDOW-bit window.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous reset, active HIGH despite the name
//   din        : received serial PRBS bit
//   din_valid  : qualifies din; nothing advances while low
//   clr        : synchronous clear of err_count / bit_count (lock unaffected)
//   locked     : high while in LOCKED
//   err_pulse  : one-cycle pulse per mismatched valid bit while LOCKED
//   err_count  : saturating error count (LOCKED only)
//   bit_count  : saturating compared-bit count (LOCKED only)
//
// Handshake: din_valid is a pure qualifier. There is no ready; every cycle
// with din_valid high consumes exactly one bit, back-to-back at full rate.

module prbs31_checker #(
    parameter int LOCK_COUNT  = 64,
    parameter int LOSS_THRESH = 8,
    parameter int LOSS_WINDOW = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        clr,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);

    localparam int WPOS_W = $clog2(LOSS_WINDOW);
    localparam logic [7:0]        LOCK_CNT_V = 8'(LOCK_COUNT);
    localparam logic [7:0]        THRESH_V   = 8'(LOSS_THRESH);
    localparam logic [WPOS_W-1:0] WPOS_MAX   = WPOS_W'(LOSS_WINDOW - 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [30:0]       s, s_n;
    logic [4:0]        fill, fill_n;
    logic [7:0]        mcnt, mcnt_n;
    logic [WPOS_W-1:0] wpos, wpos_n;
    logic [7:0]        werr, werr_n;
    logic [15:0]       err_count_n;
    logic [31:0]       bit_count_n;
    logic              err_pulse_n;

    logic       pred;
    logic       bit_err;
    logic [7:0] mcnt_inc;
    logic [7:0] werr_cur;

    // Predicted next bit: same taps as the generator (lag 28 and lag 31).
    assign pred     = s[27] ^ s[30];
    assign bit_err  = din ^ pred;
    assign mcnt_inc = mcnt + 8'd1;
    // Window error count including the bit being judged right now.
    assign werr_cur = werr + {7'd0, bit_err};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= SEARCH;
            s         <= '0;
            fill      <= '0;
            mcnt      <= '0;
            wpos      <= '0;
            werr      <= '0;
            err_count <= '0;
            bit_count <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            s         <= s_n;
            fill      <= fill_n;
            mcnt      <= mcnt_n;
            wpos      <= wpos_n;
            werr      <= werr_n;
            err_count <= err_count_n;
            bit_count <= bit_count_n;
            err_pulse <= err_pulse_n;
        end
    end

    always_comb begin
        state_n     = state;
        s_n         = s;
        fill_n      = fill;
        mcnt_n      = mcnt;
        wpos_n      = wpos;
        werr_n      = werr;
        err_count_n = err_count;
        bit_count_n = bit_count;
        err_pulse_n = 1'b0;

        if (din_valid) begin
            case (state)
                SEARCH: begin
                    s_n = {s[29:0], din};
                    if (fill < 5'd31) begin
                        fill_n = fill + 5'd1;
                    end else if (bit_err || (s == 31'd0)) begin
                        // An all-zero register predicts zeros forever; never
                        // let that lockup state count toward lock.
                        mcnt_n = 8'd0;
                    end else begin
                        mcnt_n = mcnt_inc;
                        if (mcnt_inc == LOCK_CNT_V) begin
                            state_n = LOCKED;
                            wpos_n  = '0;
                            werr_n  = 8'd0;
                        end
                    end
                end
                LOCKED: begin
                    // Free-run on our own prediction so a line error is
                    // counted once and never reaches the taps.
                    s_n = {s[29:0], pred};
                    if (bit_count != 32'hFFFF_FFFF) begin
                        bit_count_n = bit_count + 32'd1;
                    end
                    if (bit_err) begin
                        err_pulse_n = 1'b1;
                        if (err_count != 16'hFFFF) begin
                            err_count_n = err_count + 16'd1;
                        end
                    end
                    if (werr_cur >= THRESH_V) begin
                        // s is kept; fill=0 forces a full refill before compares.
                        state_n = SEARCH;
                        fill_n  = 5'd0;
                        mcnt_n  = 8'd0;
                        wpos_n  = '0;
                        werr_n  = 8'd0;
                    end else if (wpos == WPOS_MAX) begin
                        wpos_n = '0;
                        werr_n = 8'd0;
                    end else begin
                        wpos_n = wpos + 1'b1;
                        werr_n = werr_cur;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end

        if (clr) begin
            err_count_n = 16'd0;
            bit_count_n = 32'd0;
        end
    end

    assign locked = (state == LOCKED);

endmodule
